// File: rtl/nvpe_data_arbiter.sv
// nvpe_data_arbiter
// Arbitrates two OBI-style data masters (M1 = CPU, M2 = NVPE) onto a single
// memory slave port and routes in-order slave responses back to the master
// that issued each transfer.
//
// Parameters:
//   MAX_OUTSTANDING  accepted-but-unanswered slave transfers allowed (1..4)
//   RR_EN            1 = round-robin on contention, 0 = M1 always wins
//
// Ports:
//   clk_i, rst_ni                 clock, asynchronous active-low reset
//   data_*_m1_i / data_*_m1_o     CPU master request / grant / response
//   data_*_m2_i / data_*_m2_o     NVPE master request / grant / response
//   data_*_s1_o / data_*_s1_i     memory slave request / grant / response
//   outstanding_o                 registered count of in-flight transfers
//   resp_err_o                    sticky: slave rvalid with nothing in flight
module nvpe_data_arbiter #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter bit          RR_EN           = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,

  input  logic        data_req_m1_i,
  input  logic        data_we_m1_i,
  input  logic [31:0] data_addr_m1_i,
  input  logic [31:0] data_wdata_m1_i,
  input  logic [3:0]  data_be_m1_i,
  output logic        data_gnt_m1_o,
  output logic        data_rvalid_m1_o,
  output logic [31:0] data_rdata_m1_o,

  input  logic        data_req_m2_i,
  input  logic        data_we_m2_i,
  input  logic [31:0] data_addr_m2_i,
  input  logic [31:0] data_wdata_m2_i,
  input  logic [3:0]  data_be_m2_i,
  output logic        data_gnt_m2_o,
  output logic        data_rvalid_m2_o,
  output logic [31:0] data_rdata_m2_o,

  output logic        data_req_s1_o,
  output logic        data_we_s1_o,
  output logic [31:0] data_addr_s1_o,
  output logic [31:0] data_wdata_s1_o,
  output logic [3:0]  data_be_s1_o,
  input  logic        data_gnt_s1_i,
  input  logic        data_rvalid_s1_i,
  input  logic [31:0] data_rdata_s1_i,

  output logic [2:0]  outstanding_o,
  output logic        resp_err_o
);

  typedef enum logic {
    MST_M1 = 1'b0,
    MST_M2 = 1'b1
  } mst_e;

  localparam logic [2:0] MAX_CNT  = 3'(MAX_OUTSTANDING);
  localparam logic [1:0] LAST_IDX = 2'(MAX_OUTSTANDING - 1);

  logic [2:0] count_q, count_d;
  // Storage is always 4 entries; only indices 0..MAX_OUTSTANDING-1 are used.
  logic [3:0] fifo_q, fifo_d;
  logic [1:0] wptr_q, wptr_d;
  logic [1:0] rptr_q, rptr_d;
  logic       lock_q, lock_d;
  mst_e       lock_id_q, lock_id_d;
  mst_e       last_q, last_d;
  logic       resp_err_q, resp_err_d;

  logic       sel_valid;
  mst_e       sel_id;
  logic       sel_req;
  logic       full;
  logic       empty;
  logic       req_s1;
  logic       accept;
  logic       pop;
  mst_e       head_id;

  // Master selection. A held lock pins the selection so the slave sees a
  // stable address until it grants.
  always_comb begin
    sel_valid = 1'b0;
    sel_id    = MST_M1;
    if (lock_q) begin
      sel_valid = 1'b1;
      sel_id    = lock_id_q;
    end else if (data_req_m1_i && !data_req_m2_i) begin
      sel_valid = 1'b1;
      sel_id    = MST_M1;
    end else if (!data_req_m1_i && data_req_m2_i) begin
      sel_valid = 1'b1;
      sel_id    = MST_M2;
    end else if (data_req_m1_i && data_req_m2_i) begin
      sel_valid = 1'b1;
      sel_id    = (RR_EN && (last_q == MST_M1)) ? MST_M2 : MST_M1;
    end
  end

  // full/empty come from the registered count only, so slave rvalid never
  // reaches the request or grant outputs combinationally.
  assign full  = (count_q == MAX_CNT);
  assign empty = (count_q == '0);

  always_comb begin
    sel_req         = 1'b0;
    data_we_s1_o    = 1'b0;
    data_addr_s1_o  = '0;
    data_wdata_s1_o = '0;
    data_be_s1_o    = '0;
    if (sel_valid) begin
      if (sel_id == MST_M1) begin
        sel_req         = data_req_m1_i;
        data_we_s1_o    = data_we_m1_i;
        data_addr_s1_o  = data_addr_m1_i;
        data_wdata_s1_o = data_wdata_m1_i;
        data_be_s1_o    = data_be_m1_i;
      end else begin
        sel_req         = data_req_m2_i;
        data_we_s1_o    = data_we_m2_i;
        data_addr_s1_o  = data_addr_m2_i;
        data_wdata_s1_o = data_wdata_m2_i;
        data_be_s1_o    = data_be_m2_i;
      end
    end
  end

  // Reset gating keeps the request (and hence both grants) low while rst_ni=0
  // even if a master is already requesting.
  assign req_s1        = rst_ni & sel_valid & sel_req & ~full;
  assign data_req_s1_o = req_s1;
  assign accept        = req_s1 & data_gnt_s1_i;

  assign data_gnt_m1_o = accept & (sel_id == MST_M1);
  assign data_gnt_m2_o = accept & (sel_id == MST_M2);

  // Response routing by FIFO head.
  assign pop     = data_rvalid_s1_i & ~empty;
  assign head_id = mst_e'(fifo_q[rptr_q]);

  assign data_rvalid_m1_o = pop & (head_id == MST_M1);
  assign data_rvalid_m2_o = pop & (head_id == MST_M2);
  assign data_rdata_m1_o  = data_rvalid_m1_o ? data_rdata_s1_i : '0;
  assign data_rdata_m2_o  = data_rvalid_m2_o ? data_rdata_s1_i : '0;

  assign outstanding_o = count_q;
  assign resp_err_o    = resp_err_q;

  always_comb begin
    count_d    = count_q;
    fifo_d     = fifo_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    lock_d     = req_s1 & ~data_gnt_s1_i;
    lock_id_d  = lock_id_q;
    last_d     = last_q;
    resp_err_d = resp_err_q | (data_rvalid_s1_i & empty);

    if (req_s1 && !data_gnt_s1_i) begin
      lock_id_d = sel_id;
    end

    if (accept) begin
      fifo_d[wptr_q] = logic'(sel_id);
      wptr_d         = (wptr_q == LAST_IDX) ? 2'd0 : wptr_q + 2'd1;
      last_d         = sel_id;
    end

    if (pop) begin
      rptr_d = (rptr_q == LAST_IDX) ? 2'd0 : rptr_q + 2'd1;
    end

    if (accept && !pop) begin
      count_d = count_q + 3'd1;
    end else if (pop && !accept) begin
      count_d = count_q - 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q    <= '0;
      fifo_q     <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      lock_q     <= 1'b0;
      lock_id_q  <= MST_M1;
      last_q     <= MST_M2;
      resp_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      lock_q     <= lock_d;
      lock_id_q  <= lock_id_d;
      last_q     <= last_d;
      resp_err_q <= resp_err_d;
    end
  end

endmodule

// File: tb/tb_nvpe_data_arbiter.sv
module tb_nvpe_data_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        req_m1, we_m1, req_m2, we_m2;
  logic [31:0] addr_m1, wdata_m1, addr_m2, wdata_m2;
  logic [3:0]  be_m1, be_m2;
  logic        gnt_s1, rvalid_s1;
  logic [31:0] rdata_s1;

  logic        gnt_m1, rvalid_m1, gnt_m2, rvalid_m2;
  logic [31:0] rdata_m1, rdata_m2;
  logic        req_s1, we_s1;
  logic [31:0] addr_s1, wdata_s1;
  logic [3:0]  be_s1;
  logic [2:0]  outstanding;
  logic        resp_err;

  logic        d2_gnt_m1, d2_rvalid_m1, d2_gnt_m2, d2_rvalid_m2;
  logic [31:0] d2_rdata_m1, d2_rdata_m2;
  logic        d2_req_s1, d2_we_s1;
  logic [31:0] d2_addr_s1, d2_wdata_s1;
  logic [3:0]  d2_be_s1;
  logic [2:0]  d2_outstanding;
  logic        d2_resp_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nvpe_data_arbiter #(.MAX_OUTSTANDING(2), .RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_m1_i(req_m1), .data_we_m1_i(we_m1), .data_addr_m1_i(addr_m1),
    .data_wdata_m1_i(wdata_m1), .data_be_m1_i(be_m1),
    .data_gnt_m1_o(gnt_m1), .data_rvalid_m1_o(rvalid_m1), .data_rdata_m1_o(rdata_m1),
    .data_req_m2_i(req_m2), .data_we_m2_i(we_m2), .data_addr_m2_i(addr_m2),
    .data_wdata_m2_i(wdata_m2), .data_be_m2_i(be_m2),
    .data_gnt_m2_o(gnt_m2), .data_rvalid_m2_o(rvalid_m2), .data_rdata_m2_o(rdata_m2),
    .data_req_s1_o(req_s1), .data_we_s1_o(we_s1), .data_addr_s1_o(addr_s1),
    .data_wdata_s1_o(wdata_s1), .data_be_s1_o(be_s1),
    .data_gnt_s1_i(gnt_s1), .data_rvalid_s1_i(rvalid_s1), .data_rdata_s1_i(rdata_s1),
    .outstanding_o(outstanding), .resp_err_o(resp_err)
  );

  // Fixed-priority, single-outstanding variant on the same stimulus.
  nvpe_data_arbiter #(.MAX_OUTSTANDING(1), .RR_EN(1'b0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n),
    .data_req_m1_i(req_m1), .data_we_m1_i(we_m1), .data_addr_m1_i(addr_m1),
    .data_wdata_m1_i(wdata_m1), .data_be_m1_i(be_m1),
    .data_gnt_m1_o(d2_gnt_m1), .data_rvalid_m1_o(d2_rvalid_m1), .data_rdata_m1_o(d2_rdata_m1),
    .data_req_m2_i(req_m2), .data_we_m2_i(we_m2), .data_addr_m2_i(addr_m2),
    .data_wdata_m2_i(wdata_m2), .data_be_m2_i(be_m2),
    .data_gnt_m2_o(d2_gnt_m2), .data_rvalid_m2_o(d2_rvalid_m2), .data_rdata_m2_o(d2_rdata_m2),
    .data_req_s1_o(d2_req_s1), .data_we_s1_o(d2_we_s1), .data_addr_s1_o(d2_addr_s1),
    .data_wdata_s1_o(d2_wdata_s1), .data_be_s1_o(d2_be_s1),
    .data_gnt_s1_i(gnt_s1), .data_rvalid_s1_i(rvalid_s1), .data_rdata_s1_i(rdata_s1),
    .outstanding_o(d2_outstanding), .resp_err_o(d2_resp_err)
  );

  typedef struct {
    logic        r1, r2, gnt, rv;
    logic [31:0] rdata;
    logic        ereq;
    logic [31:0] eaddr;
    logic        eg1, eg2, erv1, erv2;
    logic [2:0]  eout;
    logic        eerr;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(input logic r1, input logic r2, input logic g,
                              input logic rv, input logic [31:0] rd,
                              input logic ereq, input logic [31:0] eaddr,
                              input logic eg1, input logic eg2,
                              input logic erv1, input logic erv2,
                              input logic [2:0] eout, input logic eerr);
    vec_t v;
    v.r1 = r1; v.r2 = r2; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.ereq = ereq; v.eaddr = eaddr; v.eg1 = eg1; v.eg2 = eg2;
    v.erv1 = erv1; v.erv2 = erv2; v.eout = eout; v.eerr = eerr;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic r2, input logic g,
                       input logic rv, input logic [31:0] rd);
    req_m1 = r1; req_m2 = r2; gnt_s1 = g; rvalid_s1 = rv; rdata_s1 = rd;
  endtask

  initial begin
    logic        ewe;
    logic [3:0]  ebe;
    logic [31:0] ewd;

    // M1 = write 0x100, M2 = read 0x200; distinct side fields expose mux faults.
    addr_m1 = 32'h100; wdata_m1 = 32'h1111_1111; be_m1 = 4'h3; we_m1 = 1'b1;
    addr_m2 = 32'h200; wdata_m2 = 32'h2222_2222; be_m2 = 4'hC; we_m2 = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    //             r1 r2 g  rv rdata         req eaddr   g1 g2 v1 v2 out err
    tbl[0]  = mk(1, 0, 1, 0, 32'h0,         1, 32'h100, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 32'hDEADBEEF,  0, 32'h0,   0, 0, 1, 0, 1, 0);
    tbl[2]  = mk(1, 1, 1, 0, 32'h0,         1, 32'h200, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(1, 1, 1, 1, 32'hA0,        1, 32'h100, 1, 0, 0, 1, 1, 0);
    tbl[4]  = mk(1, 1, 1, 1, 32'hA1,        1, 32'h200, 0, 1, 1, 0, 1, 0);
    tbl[5]  = mk(1, 1, 1, 1, 32'hA2,        1, 32'h100, 1, 0, 0, 1, 1, 0);
    tbl[6]  = mk(0, 0, 0, 1, 32'hA3,        0, 32'h0,   0, 0, 1, 0, 1, 0);
    tbl[7]  = mk(0, 1, 1, 0, 32'h0,         1, 32'h200, 0, 1, 0, 0, 0, 0);
    tbl[8]  = mk(0, 0, 0, 1, 32'hB0,        0, 32'h0,   0, 0, 0, 1, 1, 0);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,         1, 32'h100, 0, 0, 0, 0, 0, 0);
    tbl[10] = mk(1, 1, 0, 0, 32'h0,         1, 32'h100, 0, 0, 0, 0, 0, 0);
    tbl[11] = mk(1, 1, 0, 0, 32'h0,         1, 32'h100, 0, 0, 0, 0, 0, 0);
    tbl[12] = mk(1, 1, 1, 0, 32'h0,         1, 32'h100, 1, 0, 0, 0, 0, 0);
    tbl[13] = mk(1, 1, 1, 0, 32'h0,         1, 32'h200, 0, 1, 0, 0, 1, 0);
    tbl[14] = mk(1, 1, 1, 0, 32'h0,         0, 32'h100, 0, 0, 0, 0, 2, 0);
    tbl[15] = mk(1, 1, 1, 1, 32'hC0,        0, 32'h100, 0, 0, 1, 0, 2, 0);
    tbl[16] = mk(1, 1, 1, 0, 32'h0,         1, 32'h100, 1, 0, 0, 0, 1, 0);
    tbl[17] = mk(0, 0, 0, 1, 32'hC1,        0, 32'h0,   0, 0, 0, 1, 2, 0);
    tbl[18] = mk(0, 0, 0, 1, 32'hC2,        0, 32'h0,   0, 0, 1, 0, 1, 0);
    tbl[19] = mk(0, 1, 1, 0, 32'h0,         1, 32'h200, 0, 1, 0, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 1, 32'hD0,        0, 32'h0,   0, 0, 0, 1, 1, 0);
    tbl[21] = mk(0, 1, 0, 0, 32'h0,         1, 32'h200, 0, 0, 0, 0, 0, 0);
    tbl[22] = mk(1, 1, 0, 0, 32'h0,         1, 32'h200, 0, 0, 0, 0, 0, 0);
    tbl[23] = mk(1, 1, 1, 0, 32'h0,         1, 32'h200, 0, 1, 0, 0, 0, 0);
    tbl[24] = mk(1, 1, 1, 0, 32'h0,         1, 32'h100, 1, 0, 0, 0, 1, 0);
    tbl[25] = mk(0, 0, 0, 1, 32'hD1,        0, 32'h0,   0, 0, 0, 1, 2, 0);
    tbl[26] = mk(0, 0, 0, 1, 32'hD2,        0, 32'h0,   0, 0, 1, 0, 1, 0);
    tbl[27] = mk(0, 0, 0, 1, 32'hE0,        0, 32'h0,   0, 0, 0, 0, 0, 0);
    tbl[28] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 0, 0, 0, 1);
    tbl[29] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,   0, 0, 0, 0, 0, 1);

    // Reset with a master already requesting: everything quiet.
    rst_n = 1'b0;
    req_m1 = 1'b1;
    #2;
    chk("rst req_s1", 32'(req_s1), 32'd0);
    chk("rst gnt_m1", 32'(gnt_m1), 32'd0);
    chk("rst out", 32'(outstanding), 32'd0);
    chk("rst err", 32'(resp_err), 32'd0);
    req_m1 = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      drive(tbl[i].r1, tbl[i].r2, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      @(negedge clk);
      ewe = 1'b0; ebe = 4'h0; ewd = 32'h0;
      if (tbl[i].eaddr == 32'h100) begin
        ewe = 1'b1; ebe = 4'h3; ewd = 32'h1111_1111;
      end else if (tbl[i].eaddr == 32'h200) begin
        ewe = 1'b0; ebe = 4'hC; ewd = 32'h2222_2222;
      end
      chk($sformatf("v%0d req_s1", i), 32'(req_s1), 32'(tbl[i].ereq));
      chk($sformatf("v%0d addr_s1", i), addr_s1, tbl[i].eaddr);
      chk($sformatf("v%0d we_s1", i), 32'(we_s1), 32'(ewe));
      chk($sformatf("v%0d be_s1", i), 32'(be_s1), 32'(ebe));
      chk($sformatf("v%0d wdata_s1", i), wdata_s1, ewd);
      chk($sformatf("v%0d gnt_m1", i), 32'(gnt_m1), 32'(tbl[i].eg1));
      chk($sformatf("v%0d gnt_m2", i), 32'(gnt_m2), 32'(tbl[i].eg2));
      chk($sformatf("v%0d rvalid_m1", i), 32'(rvalid_m1), 32'(tbl[i].erv1));
      chk($sformatf("v%0d rvalid_m2", i), 32'(rvalid_m2), 32'(tbl[i].erv2));
      chk($sformatf("v%0d rdata_m1", i), rdata_m1, tbl[i].erv1 ? tbl[i].rdata : 32'h0);
      chk($sformatf("v%0d rdata_m2", i), rdata_m2, tbl[i].erv2 ? tbl[i].rdata : 32'h0);
      chk($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(tbl[i].eout));
      chk($sformatf("v%0d resp_err", i), 32'(resp_err), 32'(tbl[i].eerr));
    end

    // Reset with two transfers in flight.
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk); chk("h0 out", 32'(outstanding), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("h1 out", 32'(outstanding), 32'd1);
    @(posedge clk); #1;
    chk("h2 out pre-reset", 32'(outstanding), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("h2 out in reset", 32'(outstanding), 32'd0);
    chk("h2 req_s1 in reset", 32'(req_s1), 32'd0);
    chk("h2 gnt_m1 in reset", 32'(gnt_m1), 32'd0);
    chk("h2 gnt_m2 in reset", 32'(gnt_m2), 32'd0);
    chk("h2 err in reset", 32'(resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, '0);

    // Response after reset belongs to nobody.
    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h5555);
    @(negedge clk);
    chk("r0 rvalid_m1", 32'(rvalid_m1), 32'd0);
    chk("r0 rvalid_m2", 32'(rvalid_m2), 32'd0);
    chk("r0 out", 32'(outstanding), 32'd0);
    chk("r0 d2 rvalid_m1", 32'(d2_rvalid_m1), 32'd0);

    // First contention after reset: M1 wins on both variants.
    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("p0 err", 32'(resp_err), 32'd1);
    chk("p0 gnt_m1", 32'(gnt_m1), 32'd1);
    chk("p0 gnt_m2", 32'(gnt_m2), 32'd0);
    chk("p0 d2 gnt_m1", 32'(d2_gnt_m1), 32'd1);
    chk("p0 d2 err", 32'(d2_resp_err), 32'd1);

    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("p1 gnt_m2", 32'(gnt_m2), 32'd1);
    chk("p1 out", 32'(outstanding), 32'd1);
    chk("p1 d2 req_s1", 32'(d2_req_s1), 32'd0);
    chk("p1 d2 gnt_m1", 32'(d2_gnt_m1), 32'd0);
    chk("p1 d2 gnt_m2", 32'(d2_gnt_m2), 32'd0);
    chk("p1 d2 out", 32'(d2_outstanding), 32'd1);

    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h77);
    @(negedge clk);
    chk("p2 req_s1", 32'(req_s1), 32'd0);
    chk("p2 out", 32'(outstanding), 32'd2);
    chk("p2 rvalid_m1", 32'(rvalid_m1), 32'd1);
    chk("p2 rdata_m1", rdata_m1, 32'h77);
    chk("p2 d2 req_s1", 32'(d2_req_s1), 32'd0);
    chk("p2 d2 rvalid_m1", 32'(d2_rvalid_m1), 32'd1);

    @(posedge clk); #1; drive(1'b1, 1'b1, 1'b1, 1'b0, '0);
    @(negedge clk);
    chk("p3 gnt_m1", 32'(gnt_m1), 32'd1);
    chk("p3 out", 32'(outstanding), 32'd1);
    chk("p3 d2 gnt_m1", 32'(d2_gnt_m1), 32'd1);
    chk("p3 d2 gnt_m2", 32'(d2_gnt_m2), 32'd0);
    chk("p3 d2 out", 32'(d2_outstanding), 32'd0);

    @(posedge clk); #1; drive(1'b0, 1'b0, 1'b0, 1'b0, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
